trap_unit: RTL
==============

Name: trap_unit

Overview:
- Machine-mode trap sequencer directly downstream of pipeline_controller.
- Consumes the prioritised exception/interrupt cause codes plus mret, and updates the trap CSRs (mstatus, mie, mip, mtvec, mepc, mcause, mtval).
- Drives a registered PC redirect and a pipeline flush to fetch.
- Owns the CSR read/write port for these seven CSRs only.

Parameters:
- XLEN, 32, data/address width
- RESET_MTVEC, 32'h0000_0000, mtvec reset value

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- exception_valid_i  in  1  synchronous exception at commit
- exception_cause_i  in  4  cause code: 0, 2, 4, 6 or 11
- exception_pc_i  in  XLEN  PC of faulting instruction
- exception_tval_i  in  XLEN  faulting address/instruction
- commit_valid_i  in  1  an instruction retires this cycle
- commit_next_pc_i  in  XLEN  PC of next instruction after commit
- interrupt_machine_software_i  in  1  MSIP level
- interrupt_machine_timer_i  in  1  MTIP level
- interrupt_machine_external_i  in  1  MEIP level
- mret_i  in  1  mret at commit
- csr_addr_i  in  12  CSR address
- csr_wr_en_i  in  1  CSR write strobe
- csr_wdata_i  in  XLEN  CSR write data
- csr_rdata_o  out  XLEN  combinational read data; 0 for unmapped addresses
- redirect_valid_o  out  1  fetch redirect strobe
- redirect_pc_o  out  XLEN  redirect target
- flush_pipeline_o  out  1  flush fetch..memory stages
- trap_busy_o  out  1  high whenever state is not IDLE

Behaviour:
- Clock/reset: one clock `clk_i`; synchronous active-high reset `rst_i`.
- Reset values:
  - state=IDLE; all outputs 0.
  - mstatus.MIE=0, mstatus.MPIE=0; mie=0; mepc=0; mcause=0; mtval=0; mtvec=RESET_MTVEC.
- CSR map and field rules:
  - mstatus 0x300: MIE bit3, MPIE bit7 writable; MPP[12:11] reads 2'b11; all other bits read 0.
  - mie 0x304: bits 3, 7, 11 writable.
  - mtvec 0x305.
  - mepc 0x341: bits[1:0] forced 0.
  - mcause 0x342.
  - mtval 0x343.
  - mip 0x344: read-only; reflects the live interrupt inputs at bits 3, 7, 11.
- FSM states: IDLE, REDIRECT.
- Event priority, sampled in IDLE only:
  - exception_valid_i beats mret_i beats interrupt.
  - Interrupt is taken only if mstatus.MIE=1 and commit_valid_i=1 and at least one (mip & mie) bit is set.
  - Interrupt priority: MEI(11) > MSI(3) > MTI(7).
- Trap entry, event sampled in cycle T; at the T+1 edge:
  - mepc <= exception_pc_i for an exception, or commit_next_pc_i for an interrupt.
  - mcause <= {is_irq, 27'b0, cause}.
  - mtval <= exception_tval_i for an exception, else 0.
  - MPIE <= MIE; MIE <= 0.
  - state <= REDIRECT.
- mret in IDLE, at the next edge:
  - MIE <= MPIE; MPIE <= 1.
  - state <= REDIRECT.
  - Target = mepc.
- REDIRECT state (exactly one cycle, then back to IDLE):
  - redirect_valid_o=1, flush_pipeline_o=1, trap_busy_o=1 (all registered outputs).
  - redirect_pc_o = trap target, or mepc for mret.
  - All events are ignored while in REDIRECT.
- Trap target: {mtvec[XLEN-1:2], 2'b00} (direct mode).
- Simultaneous CSR write and trap/mret in the same cycle: the hardware update wins on every field it touches; the CSR write still lands on untouched CSRs.
- Unmapped CSR writes are ignored.
- Interrupt inputs are level-sensitive; the block performs no clearing.
- Reset asserted in REDIRECT: return to IDLE next edge, redirect suppressed.

Optional Feature:
- Macro: VECTORED_MTVEC_EN
- Defined:
  - mtvec[1:0] writable; mode 01 is vectored.
  - In vectored mode, an interrupt target is {mtvec[XLEN-1:2],2'b00} + 4*cause.
  - Exceptions always go to base.
  - Mode values 10 and 11 are ignored on write; the old mode is kept.
- Undefined: mtvec[1:0] reads 0; direct mode only.

Test Plan:
- Illegal instruction: mtvec=0x100, exception_cause_i=2, pc=0x2004, tval=0x0000_FFFF -> next cycle redirect_valid_o=1, redirect_pc_o=0x100, flush=1; mepc=0x2004, mcause=0x2, mtval=0xFFFF; MIE 1->0, MPIE=1.
- Timer interrupt: MIE=1, mie[7]=1, MTIP=1, commit_valid_i=1, commit_next_pc_i=0x3000 -> mcause=0x8000_0007, mepc=0x3000, mtval=0, redirect to 0x100.
- Simultaneous MEIP+MSIP+MTIP all enabled -> mcause=0x8000_000B; with exception_valid_i also high (cause 11) -> mcause=0x0000_000B.
- mret after the above -> redirect_pc_o=mepc, MIE=1, MPIE=1; a second event during REDIRECT produces no redirect.
- CSR write to mstatus (MIE=1) in the same cycle as an ecall -> MIE=0 after the edge; write mepc=0x1003 -> reads 0x1000; read 0x7C0 -> 0.
- VECTORED_MTVEC_EN defined: mtvec=0x201, MTI taken -> redirect_pc_o=0x21C; ecall -> 0x200.

Source files
------------

// File: rtl/trap_unit_if.sv
// Commit-side trap event, CSR port and fetch-redirect bundle between pipeline and trap_unit.
interface trap_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            exception_valid_i;
  logic [3:0]      exception_cause_i;
  logic [XLEN-1:0] exception_pc_i;
  logic [XLEN-1:0] exception_tval_i;
  logic            commit_valid_i;
  logic [XLEN-1:0] commit_next_pc_i;
  logic            interrupt_machine_software_i;
  logic            interrupt_machine_timer_i;
  logic            interrupt_machine_external_i;
  logic            mret_i;
  logic [11:0]     csr_addr_i;
  logic            csr_wr_en_i;
  logic [XLEN-1:0] csr_wdata_i;
  logic [XLEN-1:0] csr_rdata_o;
  logic            redirect_valid_o;
  logic [XLEN-1:0] redirect_pc_o;
  logic            flush_pipeline_o;
  logic            trap_busy_o;

  modport master (
    output exception_valid_i, exception_cause_i, exception_pc_i, exception_tval_i,
           commit_valid_i, commit_next_pc_i, interrupt_machine_software_i,
           interrupt_machine_timer_i, interrupt_machine_external_i, mret_i,
           csr_addr_i, csr_wr_en_i, csr_wdata_i,
    input  csr_rdata_o, redirect_valid_o, redirect_pc_o, flush_pipeline_o, trap_busy_o
  );

  modport slave (
    input  exception_valid_i, exception_cause_i, exception_pc_i, exception_tval_i,
           commit_valid_i, commit_next_pc_i, interrupt_machine_software_i,
           interrupt_machine_timer_i, interrupt_machine_external_i, mret_i,
           csr_addr_i, csr_wr_en_i, csr_wdata_i,
    output csr_rdata_o, redirect_valid_o, redirect_pc_o, flush_pipeline_o, trap_busy_o
  );
endinterface

// File: rtl/trap_unit.sv
// M-mode trap/mret sequencer and trap CSRs; redirect+flush one cycle after the event, no backpressure
// (events are ignored while busy). VECTORED_MTVEC_EN enables vectored mtvec for interrupts.
module trap_unit #(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_MTVEC = 32'h0000_0000
) (
  input logic        clk_i,
  input logic        rst_i,
  trap_unit_if.slave bus
);
  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MTVAL   = 12'h343;
  localparam logic [11:0] ADDR_MIP     = 12'h344;
  localparam logic [XLEN-1:0] IRQ_MASK   = {{(XLEN-12){1'b0}}, 12'h888};
  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  typedef enum logic {IDLE = 1'b0, REDIRECT = 1'b1} state_t;
  state_t state_q, state_d;

  logic            mstatus_mie_q, mstatus_mpie_q;
  logic [XLEN-1:0] mie_q, mtvec_q, mepc_q, mcause_q, mtval_q;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic [XLEN-1:0] mip_w, pending;
  logic            take_exc, take_mret, take_irq;
  logic [3:0]      irq_cause;
  logic [XLEN-1:0] trap_base, trap_target;

  always_comb begin
    mip_w     = '0;
    mip_w[3]  = bus.interrupt_machine_software_i;
    mip_w[7]  = bus.interrupt_machine_timer_i;
    mip_w[11] = bus.interrupt_machine_external_i;
  end

  assign pending   = mip_w & mie_q;
  assign irq_cause = pending[11] ? 4'd11 : (pending[3] ? 4'd3 : 4'd7);

  assign take_exc  = (state_q == IDLE) && bus.exception_valid_i;
  assign take_mret = (state_q == IDLE) && !bus.exception_valid_i && bus.mret_i;
  assign take_irq  = (state_q == IDLE) && !bus.exception_valid_i && !bus.mret_i &&
                     mstatus_mie_q && bus.commit_valid_i && (|pending);

  assign trap_base = mtvec_q & ALIGN_MASK;
`ifdef VECTORED_MTVEC_EN
  // Only interrupts are vectored; exceptions always land on the base.
  assign trap_target = (take_irq && (mtvec_q[1:0] == 2'b01)) ?
                       trap_base + {{(XLEN-6){1'b0}}, irq_cause, 2'b00} : trap_base;
`else
  assign trap_target = trap_base;
`endif

  always_comb begin
    state_d       = state_q;
    redirect_pc_d = '0;
    case (state_q)
      IDLE: begin
        if (take_exc || take_irq) begin
          state_d       = REDIRECT;
          redirect_pc_d = trap_target;
        end else if (take_mret) begin
          state_d       = REDIRECT;
          redirect_pc_d = mepc_q;
        end
      end
      REDIRECT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign bus.redirect_valid_o = (state_q == REDIRECT);
  assign bus.flush_pipeline_o = (state_q == REDIRECT);
  assign bus.trap_busy_o      = (state_q != IDLE);
  assign bus.redirect_pc_o    = redirect_pc_q;

  // Software write first, hardware update second: the later NBA wins on shared fields.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
`ifdef VECTORED_MTVEC_EN
      mtvec_q        <= RESET_MTVEC;
`else
      mtvec_q        <= RESET_MTVEC & ALIGN_MASK;
`endif
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
    end else begin
      if (bus.csr_wr_en_i) begin
        case (bus.csr_addr_i)
          ADDR_MSTATUS: begin
            mstatus_mie_q  <= bus.csr_wdata_i[3];
            mstatus_mpie_q <= bus.csr_wdata_i[7];
          end
          ADDR_MIE: mie_q <= bus.csr_wdata_i & IRQ_MASK;
`ifdef VECTORED_MTVEC_EN
          ADDR_MTVEC: begin
            if (bus.csr_wdata_i[1]) mtvec_q <= {bus.csr_wdata_i[XLEN-1:2], mtvec_q[1:0]};
            else                    mtvec_q <= bus.csr_wdata_i;
          end
`else
          ADDR_MTVEC: mtvec_q <= bus.csr_wdata_i & ALIGN_MASK;
`endif
          ADDR_MEPC:   mepc_q   <= bus.csr_wdata_i & ALIGN_MASK;
          ADDR_MCAUSE: mcause_q <= bus.csr_wdata_i;
          ADDR_MTVAL:  mtval_q  <= bus.csr_wdata_i;
          default: ;
        endcase
      end
      if (take_exc || take_irq) begin
        mepc_q         <= (take_exc ? bus.exception_pc_i : bus.commit_next_pc_i) & ALIGN_MASK;
        mcause_q       <= take_exc ? {1'b0, {(XLEN-5){1'b0}}, bus.exception_cause_i}
                                   : {1'b1, {(XLEN-5){1'b0}}, irq_cause};
        mtval_q        <= take_exc ? bus.exception_tval_i : '0;
        mstatus_mpie_q <= mstatus_mie_q;
        mstatus_mie_q  <= 1'b0;
      end else if (take_mret) begin
        mstatus_mie_q  <= mstatus_mpie_q;
        mstatus_mpie_q <= 1'b1;
      end
    end
  end

  always_comb begin
    bus.csr_rdata_o = '0;
    case (bus.csr_addr_i)
      ADDR_MSTATUS: begin
        bus.csr_rdata_o[12:11] = 2'b11;
        bus.csr_rdata_o[7]     = mstatus_mpie_q;
        bus.csr_rdata_o[3]     = mstatus_mie_q;
      end
      ADDR_MIE:    bus.csr_rdata_o = mie_q;
      ADDR_MTVEC:  bus.csr_rdata_o = mtvec_q;
      ADDR_MEPC:   bus.csr_rdata_o = mepc_q;
      ADDR_MCAUSE: bus.csr_rdata_o = mcause_q;
      ADDR_MTVAL:  bus.csr_rdata_o = mtval_q;
      ADDR_MIP:    bus.csr_rdata_o = mip_w;
      default:     bus.csr_rdata_o = '0;
    endcase
  end
endmodule
